sync_fifo_flags: RTL
====================

# sync_fifo_flags

Parametrised single-clock FIFO for buffering streams between producer and consumer blocks in the same clock domain. It extends the basic synchronous FIFO with an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags with a clear. A selectable read mode supports either show-ahead (first-word-fall-through) data or registered read data with a valid strobe.

## Interface
- DATA_WIDTH, 8: width of each stored word.
- ADDR_WIDTH, 4: DEPTH = 2^ADDR_WIDTH words; legal range ≥ 1.
- FWFT, 1: 1 = show-ahead read; 0 = registered read.
- AFULL_THRESH, 12: almost_full asserts when count ≥ this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 2: almost_empty asserts when count ≤ this value; legal range 0..DEPTH-1.

Ports:
- clk  in  1  rising-edge clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push request.
- wr_data  in  DATA_WIDTH  push data.
- rd_en  in  1  pop request.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  FWFT=0: one-cycle strobe marking new rd_data. FWFT=1: equals !empty.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AFULL_THRESH.
- almost_empty  out  1  count ≤ AEMPTY_THRESH.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.
- clr_err  in  1  clears overflow and underflow.

## Operation
- Storage:
  - DEPTH × DATA_WIDTH array, not reset.
  - Write and read pointers are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits index the array and wrap modulo DEPTH.
- Accept rules, using flag values before the clock edge:
  - push_ok = wr_en & !full.
  - pop_ok = rd_en & !empty.
  - A push while full is dropped, even if a pop is accepted in the same cycle.
  - A pop while empty is rejected, even if a push is accepted in the same cycle.
- Count update:
  - push_ok only: +1.
  - pop_ok only: −1.
  - Both or neither: unchanged.
  - count is a register, never out of 0..DEPTH.
- Flags (full, empty, almost_full, almost_empty, rd_valid in FWFT=1) are combinational from registered state only. No input-to-output combinational paths.
- FWFT=1: rd_data = mem[rd_ptr] continuously; pop_ok advances rd_ptr.
- FWFT=0: on pop_ok, rd_data is loaded with mem[rd_ptr] and rd_valid=1 for the next cycle only. Otherwise rd_data holds its value and rd_valid=0.
- Error flags:
  - overflow is set on wr_en & full; underflow is set on rd_en & empty.
  - Both are cleared on clr_err.
  - If a set event and clr_err occur in the same cycle, set wins.
  - rst clears both.

## Timing
- Reset (rst high at a clock edge) sets:
  - Pointers and count = 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - overflow=0, underflow=0, rd_valid=0.
  - rd_data=0 in FWFT=0. In FWFT=1, rd_data is undefined until the first write.
- Reset mid-operation discards all contents, and rst has priority over wr_en, rd_en and clr_err in that cycle. Array contents are stale but unreachable after reset.
- Write-to-read latency:
  - A word pushed at edge N drives empty=0 after edge N.
  - FWFT=1: visible on rd_data after edge N.
  - FWFT=0: earliest rd_valid is after edge N+1, when the pop is issued in cycle N+1.
- Sustained throughput: one push and one pop per cycle, with count held constant when neither full nor empty.
- Wrap-around: pointers run continuously past DEPTH. Full and empty are decided by count (equivalently, pointer MSB differs with low bits equal), never by low bits alone.

## Test plan
- Reset, fill and drain: DEPTH=16, FWFT=1. Reset, then push 0x00..0x0F on consecutive cycles.
  - Expect full=1 and count=16 after the 16th edge.
  - almost_full rises when count=12.
  - Drain returns 0x00..0x0F in order; empty=1 after the last pop.
- Overflow and underflow: with FWFT=1 and the FIFO full, push 0xAA.
  - Expect count to stay 16, overflow=1 (sticky), and 0xAA never read.
  - Drain to empty, then pop: underflow=1.
  - Assert clr_err: both clear next cycle. clr_err together with a new overflow leaves overflow=1.
- Simultaneous push and pop: count=5, wr_en=rd_en=1 for 40 cycles.
  - Expect count constant at 5, pointers wrap twice, and data order preserved.
  - At count=0 with both asserted: only the push is accepted, count=1, underflow=1.
  - At count=16 with both asserted: only the pop is accepted, count=15, overflow=1.
- Registered read mode: FWFT=0, push 0x11, 0x22.
  - Pop at cycle N: rd_data=0x11 and rd_valid=1 in N+1 only, and rd_data holds 0x11 through N+2.
  - Back-to-back pops give 0x11 then 0x22 on consecutive cycles.
- Threshold edges: AEMPTY_THRESH=2, AFULL_THRESH=12.
  - almost_empty=1 at counts 0..2 and 0 at 3.
  - almost_full=0 at 11 and 1 at 12..16.
  - Check both on increment and decrement.
- Mid-operation reset: at count=9 with overflow=1, assert rst together with wr_en=1.
  - Expect count=0, empty=1, overflow=0, and no write accepted that cycle.
  - A subsequent push of 0x5A is read back first.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and a selectable show-ahead or registered read port.
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FWFT          = 1,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    localparam logic [PW-1:0] ONE_V    = PW'(1);
    localparam logic [PW-1:0] ZERO_V   = PW'(0);
    localparam logic [PW-1:0] MSB_V    = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_V  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_V = PW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] count_r;
    logic [PW-1:0] wr_ptr_next_s;
    logic [PW-1:0] rd_ptr_next_s;
    logic [PW-1:0] count_next_s;

    logic full_r;
    logic empty_r;
    logic afull_r;
    logic aempty_r;
    logic overflow_r;
    logic underflow_r;

    logic push_ok_s;
    logic pop_ok_s;

    // Accept decisions and next pointer/count values, all from pre-edge flags.
    always_comb begin
        push_ok_s     = wr_en & ~full_r;
        pop_ok_s      = rd_en & ~empty_r;
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;

        if (push_ok_s) begin
            wr_ptr_next_s = wr_ptr_r + ONE_V;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (pop_ok_s) begin
            rd_ptr_next_s = rd_ptr_r + ONE_V;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + ONE_V;
            2'b01:   count_next_s = count_r - ONE_V;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, count and occupancy flags; flags are registered from next state
    // so they change in the same cycle as count would imply.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= ZERO_V;
            rd_ptr_r <= ZERO_V;
            count_r  <= ZERO_V;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            // Wrap-safe full/empty: MSB differs with equal low bits means full.
            full_r   <= ((wr_ptr_next_s ^ rd_ptr_next_s) == MSB_V);
            empty_r  <= (wr_ptr_next_s == rd_ptr_next_s);
            afull_r  <= (count_next_s >= AFULL_V);
            aempty_r <= (count_next_s <= AEMPTY_V);
        end
    end

    // Storage array write; no reset, contents after reset are unreachable.
    always_ff @(posedge clk) begin
        if (!rst && push_ok_s) begin
            mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Sticky error flags; a new error event wins over clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_en && full_r) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end

            if (rd_en && empty_r) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
            assign rd_valid = ~empty_r;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_data_r;
            logic                  rd_valid_r;

            // Registered read port: load on an accepted pop, strobe valid for one cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_r  <= {DATA_WIDTH{1'b0}};
                    rd_valid_r <= 1'b0;
                end else if (pop_ok_s) begin
                    rd_data_r  <= mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
                    rd_valid_r <= 1'b1;
                end else begin
                    rd_data_r  <= rd_data_r;
                    rd_valid_r <= 1'b0;
                end
            end

            assign rd_data  = rd_data_r;
            assign rd_valid = rd_valid_r;
        end
    endgenerate

    assign count        = count_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = afull_r;
    assign almost_empty = aempty_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule
